// File: rtl/fpu_round_pack.sv
// Two-stage round-and-pack back end of the muldiv unit: normalizes the
// unrounded significand, rounds it, checks the exponent range and packs a double or single result.
module fpu_round_pack #(
   parameter int FQ_W = 57,
   parameter int EQ_W = 13
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic            db,
   input  logic [2:0]      rm,
   input  logic [FQ_W-1:0] fq,
   input  logic [EQ_W-1:0] eq,
   input  logic            sq,
   input  logic [57:0]     flq,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [63:0]     res,
   output logic [4:0]      flags
);

   // Two guard bits of headroom so exponent increments can never wrap.
   localparam int EW = EQ_W + 2;

   localparam logic [2:0] RM_RNE = 3'b000;
   localparam logic [2:0] RM_RTZ = 3'b001;
   localparam logic [2:0] RM_RDN = 3'b010;
   localparam logic [2:0] RM_RUP = 3'b011;
   localparam logic [2:0] RM_RMM = 3'b100;

   logic s2_advance;

   // ---------------- stage 1: normalize and decide the increment ----------------
   logic [54:0]          n;
   logic signed [EW-1:0] e1;
   logic                 st0;
   logic [51:0]          frac1;
   logic                 g1;
   logic                 s1b;
   logic                 lsb1;
   logic                 inc1;
   logic                 zero1;

   always_comb begin
      // n holds only the fraction bits below the hidden one
      n     = fq[56] ? fq[55:1] : fq[54:0];
      st0   = fq[56] & fq[0];
      e1    = $signed({{2{eq[EQ_W-1]}}, eq}) + (fq[56] ? EW'(1) : EW'(0));
      zero1 = ~(fq[56] | fq[55]);
      if (db) begin
         frac1 = n[54:3];
         g1    = n[2];
         s1b   = st0 | (|n[1:0]);
         lsb1  = n[3];
      end else begin
         frac1 = {29'b0, n[54:32]};
         g1    = n[31];
         s1b   = st0 | (|n[30:0]);
         lsb1  = n[32];
      end
      case (rm)
         RM_RNE:  inc1 = g1 & (s1b | lsb1);
         RM_RTZ:  inc1 = 1'b0;
         RM_RDN:  inc1 = sq & (g1 | s1b);
         RM_RUP:  inc1 = ~sq & (g1 | s1b);
         RM_RMM:  inc1 = g1;
         default: inc1 = 1'b0;
      endcase
   end

   logic                 s1_valid;
   logic                 s1_sign;
   logic                 s1_db;
   logic [2:0]           s1_rm;
   logic [51:0]          s1_frac;
   logic signed [EW-1:0] s1_exp;
   logic                 s1_inc;
   logic                 s1_nx;
   logic                 s1_zero;
   logic                 s1_special;
   logic                 s1_sp_zero;
   logic                 s1_sp_inf;
   logic                 s1_sp_nan;
   logic                 s1_nv;
   logic                 s1_dz;
   logic [51:0]          s1_payload;

   assign s2_advance = ~out_valid | out_ready;
   assign in_ready   = ~s1_valid | s2_advance;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid   <= 1'b0;
         s1_sign    <= 1'b0;
         s1_db      <= 1'b0;
         s1_rm      <= 3'b0;
         s1_frac    <= '0;
         s1_exp     <= '0;
         s1_inc     <= 1'b0;
         s1_nx      <= 1'b0;
         s1_zero    <= 1'b0;
         s1_special <= 1'b0;
         s1_sp_zero <= 1'b0;
         s1_sp_inf  <= 1'b0;
         s1_sp_nan  <= 1'b0;
         s1_nv      <= 1'b0;
         s1_dz      <= 1'b0;
         s1_payload <= '0;
      end else if (in_ready) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_sign    <= sq;
            s1_db      <= db;
            s1_rm      <= rm;
            s1_frac    <= frac1;
            s1_exp     <= e1;
            s1_inc     <= inc1;
            s1_nx      <= g1 | s1b;
            s1_zero    <= zero1;
            s1_special <= flq[57];
            s1_sp_zero <= flq[56];
            s1_sp_inf  <= flq[55];
            s1_sp_nan  <= flq[54];
            s1_nv      <= flq[53];
            s1_dz      <= flq[52];
            s1_payload <= flq[51:0];
         end
      end
   end

   // ---------------- stage 2: round, range check, pack ----------------
   logic [52:0]          frac_sum;
   logic                 carry;
   logic signed [EW-1:0] e2;
   logic signed [EW-1:0] emax;
   logic                 of2;
   logic                 uf2;
   logic                 to_inf;
   logic [63:0]          res_next;
   logic [4:0]           flags_next;

   always_comb begin
      // hidden bit is always 1 here, so a fraction carry-out is a mantissa carry-out
      frac_sum = {1'b0, s1_frac} + {52'b0, s1_inc};
      carry    = s1_db ? frac_sum[52] : frac_sum[23];
      e2       = s1_exp + (carry ? EW'(1) : EW'(0));
      emax     = s1_db ? EW'(2047) : EW'(255);
      of2      = (e2 >= emax);
      uf2      = (e2 <= EW'(0));
      to_inf   = (s1_rm == RM_RNE) | (s1_rm == RM_RMM) |
                 ((s1_rm == RM_RUP) & ~s1_sign) | ((s1_rm == RM_RDN) & s1_sign);
      res_next   = '0;
      flags_next = '0;
      if (s1_special) begin
         flags_next = {s1_nv, s1_dz, 3'b000};
         if (s1_sp_zero)
            res_next = s1_db ? {s1_sign, 63'b0} : {32'b0, s1_sign, 31'b0};
         else if (s1_sp_inf)
            res_next = s1_db ? {s1_sign, 11'h7FF, 52'b0} : {32'b0, s1_sign, 8'hFF, 23'b0};
         else if (s1_sp_nan)
            res_next = s1_db ? {s1_sign, 11'h7FF, 1'b1, s1_payload[50:0]}
                             : {32'b0, s1_sign, 8'hFF, 1'b1, s1_payload[21:0]};
         else
            res_next = s1_db ? {1'b0, 11'h7FF, 1'b1, 51'b0} : {32'b0, 1'b0, 8'hFF, 1'b1, 22'b0};
      end else if (s1_zero) begin
         res_next = s1_db ? {s1_sign, 63'b0} : {32'b0, s1_sign, 31'b0};
      end else if (of2) begin
         flags_next = 5'b00101;
         if (to_inf)
            res_next = s1_db ? {s1_sign, 11'h7FF, 52'b0} : {32'b0, s1_sign, 8'hFF, 23'b0};
         else
            res_next = s1_db ? {s1_sign, 11'h7FE, {52{1'b1}}} : {32'b0, s1_sign, 8'hFE, {23{1'b1}}};
      end else if (uf2) begin
         flags_next = 5'b00011;
         res_next   = s1_db ? {s1_sign, 63'b0} : {32'b0, s1_sign, 31'b0};
      end else begin
         flags_next = {4'b0000, s1_nx};
         res_next   = s1_db ? {s1_sign, e2[10:0], frac_sum[51:0]}
                            : {32'b0, s1_sign, e2[7:0], frac_sum[22:0]};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         res       <= '0;
         flags     <= '0;
      end else if (s2_advance) begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            res   <= res_next;
            flags <= flags_next;
         end
      end
   end

endmodule

// File: tb/tb_fpu_round_pack.sv
// Directed-vector bench for fpu_round_pack: rounding modes, range limits,
// specials, backpressure and mid-flight reset, each against hand-computed results.
module tb_fpu_round_pack;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic        db;
   logic [2:0]  rm;
   logic [56:0] fq;
   logic [12:0] eq;
   logic        sq;
   logic [57:0] flq;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] res;
   logic [4:0]  flags;

   int checks = 0;
   int errors = 0;

   localparam logic [56:0] ONE  = 57'h080000000000000;
   localparam logic [56:0] TWO  = 57'h100000000000000;
   localparam logic [57:0] F_SP = 58'd1 << 57;
   localparam logic [57:0] F_Z  = 58'd1 << 56;
   localparam logic [57:0] F_I  = 58'd1 << 55;
   localparam logic [57:0] F_Q  = 58'd1 << 54;
   localparam logic [57:0] F_NV = 58'd1 << 53;
   localparam logic [57:0] F_DZ = 58'd1 << 52;

   fpu_round_pack #(.FQ_W(57), .EQ_W(13)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .db(db), .rm(rm), .fq(fq), .eq(eq), .sq(sq), .flq(flq),
      .out_valid(out_valid), .out_ready(out_ready), .res(res), .flags(flags)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        d;
      logic [2:0]  r;
      logic [56:0] f;
      logic [12:0] e;
      logic        s;
      logic [57:0] fl;
      logic [63:0] xr;
      logic [4:0]  xf;
   } vec_t;

   function automatic vec_t mk(input logic d, input logic [2:0] r, input logic [56:0] f,
                               input logic [12:0] e, input logic s, input logic [57:0] fl,
                               input logic [63:0] xr, input logic [4:0] xf);
      vec_t v;
      v.d = d; v.r = r; v.f = f; v.e = e; v.s = s; v.fl = fl; v.xr = xr; v.xf = xf;
      return v;
   endfunction

   // Drives one op with out_ready=1 and returns the result; entered and left at edge+1.
   task automatic run_op(input vec_t v, output logic [63:0] o_res, output logic [4:0] o_flags);
      int t = 0;
      db = v.d; rm = v.r; fq = v.f; eq = v.e; sq = v.s; flq = v.fl;
      in_valid = 1'b1; out_ready = 1'b1;
      #1;
      while (!in_ready && t < 20) begin @(posedge clk); #1; t++; end
      @(posedge clk); #1;
      in_valid = 1'b0;
      while (!out_valid && t < 20) begin @(posedge clk); #1; t++; end
      o_res = res; o_flags = flags;
      if (t >= 20) begin
         checks++; errors++;
         $display("FAIL op_timeout: out_valid=%b required 1 within 20 cycles", out_valid);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      checks++;
      if (out_valid !== 1'b0 || res !== 64'h0 || flags !== 5'h0) begin
         errors++;
         $display("FAIL reset_outputs: out_valid=%b res=%h flags=%b required 0/0/0", out_valid, res, flags);
      end
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_in_ready: got %b required 1", in_ready);
      end
   endtask

   task automatic test_basic();
      db = 1'b1; rm = 3'b000; fq = ONE; eq = 13'd1023; sq = 1'b0; flq = '0;
      in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL latency_early: out_valid=%b required 0 one cycle after accept", out_valid);
      end
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || res !== 64'h3FF0000000000000 || flags !== 5'b00000) begin
         errors++;
         $display("FAIL basic_one: out_valid=%b res=%h flags=%b required 1/3ff0000000000000/00000",
                  out_valid, res, flags);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_vectors(input string name, input vec_t v[], input int cnt);
      logic [63:0] r;
      logic [4:0]  f;
      for (int i = 0; i < cnt; i++) begin
         run_op(v[i], r, f);
         checks++;
         if (r !== v[i].xr || f !== v[i].xf) begin
            errors++;
            $display("FAIL %s[%0d]: res=%h flags=%b required res=%h flags=%b",
                     name, i, r, f, v[i].xr, v[i].xf);
         end
      end
   endtask

   task automatic test_normalize();
      vec_t v[];
      v = new[3];
      v[0] = mk(1, 3'b000, TWO, 13'd1023, 0, '0, 64'h4000000000000000, 5'b00000);
      v[1] = mk(0, 3'b000, TWO, 13'd127,  0, '0, 64'h0000000040000000, 5'b00000);
      v[2] = mk(1, 3'b011, 57'h100000000000001, 13'd1023, 0, '0, 64'h4000000000000001, 5'b00001);
      test_vectors("normalize", v, 3);
   endtask

   task automatic test_rounding();
      vec_t v[];
      v = new[8];
      v[0] = mk(1, 3'b000, 57'h080000000000004, 13'd1023, 0, '0, 64'h3FF0000000000000, 5'b00001);
      v[1] = mk(1, 3'b011, 57'h080000000000004, 13'd1023, 0, '0, 64'h3FF0000000000001, 5'b00001);
      v[2] = mk(1, 3'b000, 57'h08000000000000C, 13'd1023, 0, '0, 64'h3FF0000000000002, 5'b00001);
      v[3] = mk(1, 3'b010, 57'h080000000000004, 13'd1023, 1, '0, 64'hBFF0000000000001, 5'b00001);
      v[4] = mk(1, 3'b100, 57'h080000000000004, 13'd1023, 0, '0, 64'h3FF0000000000001, 5'b00001);
      v[5] = mk(1, 3'b000, 57'h0FFFFFFFFFFFFFF, 13'd1023, 0, '0, 64'h4000000000000000, 5'b00001);
      v[6] = mk(1, 3'b001, 57'h0FFFFFFFFFFFFFF, 13'd1023, 0, '0, 64'h3FFFFFFFFFFFFFFF, 5'b00001);
      v[7] = mk(0, 3'b000, 57'h080000080000001, 13'd127,  0, '0, 64'h000000003F800001, 5'b00001);
      test_vectors("rounding", v, 8);
   endtask

   task automatic test_range();
      vec_t v[];
      v = new[9];
      v[0] = mk(1, 3'b000, ONE, 13'd2047, 0, '0, 64'h7FF0000000000000, 5'b00101);
      v[1] = mk(1, 3'b001, ONE, 13'd2047, 0, '0, 64'h7FEFFFFFFFFFFFFF, 5'b00101);
      v[2] = mk(1, 3'b010, ONE, 13'd2047, 1, '0, 64'hFFF0000000000000, 5'b00101);
      v[3] = mk(1, 3'b010, ONE, 13'd2047, 0, '0, 64'h7FEFFFFFFFFFFFFF, 5'b00101);
      v[4] = mk(0, 3'b011, ONE, 13'd255,  0, '0, 64'h000000007F800000, 5'b00101);
      v[5] = mk(1, 3'b000, ONE, 13'd2046, 0, '0, 64'h7FE0000000000000, 5'b00000);
      v[6] = mk(1, 3'b000, ONE, 13'd0,    0, '0, 64'h0000000000000000, 5'b00011);
      v[7] = mk(1, 3'b000, ONE, 13'h1FFB, 1, '0, 64'h8000000000000000, 5'b00011);
      v[8] = mk(1, 3'b000, ONE, 13'd1,    0, '0, 64'h0010000000000000, 5'b00000);
      test_vectors("range", v, 9);
   endtask

   task automatic test_special();
      vec_t v[];
      v = new[6];
      v[0] = mk(1, 3'b000, ONE, 13'd1023, 1, F_SP | F_Z, 64'h8000000000000000, 5'b00000);
      v[1] = mk(1, 3'b000, ONE, 13'd1023, 0, F_SP | F_I | F_DZ, 64'h7FF0000000000000, 5'b01000);
      v[2] = mk(1, 3'b000, ONE, 13'd1023, 0, F_SP | F_Q | F_NV | 58'd5, 64'h7FF8000000000005, 5'b10000);
      v[3] = mk(0, 3'b000, ONE, 13'd127,  0, F_SP | F_Q | 58'h123, 64'h000000007FC00123, 5'b00000);
      v[4] = mk(1, 3'b000, 57'h0, 13'd1023, 1, '0, 64'h8000000000000000, 5'b00000);
      v[5] = mk(0, 3'b000, 57'h0, 13'd127,  1, '0, 64'h0000000080000000, 5'b00000);
      test_vectors("special", v, 6);
   endtask

   task automatic test_back_to_back();
      logic [63:0] exp_q [4];
      int idx = 0, nout = 0, acc_cnt = 0;
      logic acc, outx;
      exp_q[0] = 64'h3E80000000000000;
      exp_q[1] = 64'h3E90000000000000;
      exp_q[2] = 64'h3EA0000000000000;
      exp_q[3] = 64'h3EB0000000000000;
      for (int c = 0; c < 40 && nout < 4; c++) begin
         out_ready = (c >= 5);
         in_valid = (idx < 4);
         db = 1'b1; rm = 3'b000; fq = ONE; eq = 13'(1000 + idx); sq = 1'b0; flq = '0;
         #1;
         acc  = in_valid & in_ready;
         outx = out_valid & out_ready;
         if (c >= 2 && c <= 4) begin
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || acc_cnt !== 2) begin
               errors++;
               $display("FAIL stall_ctrl[%0d]: in_ready=%b out_valid=%b accepts=%0d required 0/1/2",
                        c, in_ready, out_valid, acc_cnt);
            end
            checks++;
            if (res !== exp_q[0] || flags !== 5'b00000) begin
               errors++;
               $display("FAIL stall_hold[%0d]: res=%h flags=%b required %h/00000", c, res, flags, exp_q[0]);
            end
         end
         if (outx) begin
            checks++;
            if (res !== exp_q[nout]) begin
               errors++;
               $display("FAIL drain_order[%0d]: res=%h required %h", nout, res, exp_q[nout]);
            end
            nout++;
         end
         if (acc) begin idx++; acc_cnt++; end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      checks++;
      if (nout !== 4) begin
         errors++;
         $display("FAIL drain_count: got %0d results required 4", nout);
      end
      for (int k = 0; k < 3; k++) begin
         #1;
         checks++;
         if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL drain_dup[%0d]: out_valid=%b required 0", k, out_valid);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset_midflight();
      logic [63:0] r;
      logic [4:0]  f;
      out_ready = 1'b0; in_valid = 1'b1;
      db = 1'b1; rm = 3'b000; fq = ONE; eq = 13'd1100; sq = 1'b0; flq = '0;
      @(posedge clk); #1;
      eq = 13'd1101;
      @(posedge clk); #1;
      in_valid = 1'b0;
      #1 rst = 1'b1;
      #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || res !== 64'h0) begin
         errors++;
         $display("FAIL midreset_clear: out_valid=%b in_ready=%b res=%h required 0/1/0", out_valid, in_ready, res);
      end
      @(posedge clk); #3;
      rst = 1'b0; out_ready = 1'b1;
      @(posedge clk); #1;
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL midreset_stale[%0d]: out_valid=%b res=%h required out_valid 0", k, out_valid, res);
         end
         @(posedge clk); #1;
      end
      run_op(mk(1, 3'b000, ONE, 13'd1024, 1, '0, 64'h0, 5'b0), r, f);
      checks++;
      if (r !== 64'hC000000000000000 || f !== 5'b00000) begin
         errors++;
         $display("FAIL midreset_first: res=%h flags=%b required c000000000000000/00000", r, f);
      end
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      db = 1'b0; rm = 3'b000; fq = '0; eq = '0; sq = 1'b0; flq = '0;
      repeat (2) @(posedge clk);
      #1;
      test_reset();
      rst = 1'b0;
      @(posedge clk); #1;
      test_reset();
      test_basic();
      test_normalize();
      test_rounding();
      test_range();
      test_special();
      test_back_to_back();
      test_reset_midflight();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
